// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// bsg_fifo_rolly_replay_ctrl: pops rolly-FIFO entries into an in-order pipe and turns
// hit/miss responses into commit (deq) and replay (roll) strobes, stalling after a miss.
module bsg_fifo_rolly_replay_ctrl #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] fifo_data_i,
  input  logic               fifo_v_i,
  output logic               fifo_yumi_o,
  output logic               fifo_deq_v_o,
  output logic               fifo_roll_v_o,
  output logic [width_p-1:0] issue_data_o,
  output logic               issue_epoch_o,
  output logic               issue_v_o,
  input  logic               issue_ready_i,
  input  logic               resp_v_i,
  input  logic               resp_miss_i,
  input  logic               resp_epoch_i,
  input  logic               flush_i,
  input  logic               refill_done_i,
  output logic               stall_o
);
  localparam int cnt_w = $clog2(els_p + 1);
  localparam logic [0:0] state_run   = 1'b0;
  localparam logic [0:0] state_stall = 1'b1;
  logic [0:0]       state_r, state_n;
  logic             epoch_r;
  logic [cnt_w-1:0] inflight_r;
  logic             cur, hit, miss;
  // Responses tagged with an older epoch belong to squashed entries and are dropped.
  always_comb begin
    cur           = reset_n_i & resp_v_i & (resp_epoch_i == epoch_r);
    hit           = cur & ~resp_miss_i;
    miss          = cur & resp_miss_i;
    fifo_deq_v_o  = hit;
    fifo_roll_v_o = miss | (reset_n_i & flush_i);
    issue_v_o     = reset_n_i & (state_r == state_run) & fifo_v_i
                  & (inflight_r < cnt_w'(els_p)) & ~fifo_roll_v_o;
    fifo_yumi_o   = issue_v_o & issue_ready_i;
    state_n       = miss ? state_stall : (refill_done_i ? state_run : state_r);
  end
  assign issue_data_o  = fifo_data_i;
  assign issue_epoch_o = epoch_r;
  assign stall_o       = (state_r == state_stall);
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= state_run;
      epoch_r    <= 1'b0;
      inflight_r <= '0;
    end else begin
      state_r    <= state_n;
      epoch_r    <= epoch_r ^ fifo_roll_v_o;
      inflight_r <= fifo_roll_v_o ? '0 : inflight_r + cnt_w'(fifo_yumi_o) - cnt_w'(hit);
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_n_i && cur) assert (inflight_r != '0);
  end
endmodule
